// File: rtl/typewriter_coupler.sv
// typewriter_coupler: couples a computer print channel and a keyboard to a typewriter with timed echo/key strobes.
// Define G15_COUPLER_KBD_FIFO_EN for a 4-entry keystroke FIFO; otherwise a single holding register is used.
module typewriter_coupler #(
    parameter int ECHO_MS = 40,
    parameter int KEY_MS  = 50,
    parameter int GAP_MS  = 10
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        TYPE,
    input  logic        TYPE_PULSE,
    input  logic [4:0]  OB,
    output logic [4:0]  LEV_OUT,
    output logic [10:0] KEY_LINES,
    output logic [4:0]  prt_data,
    output logic        prt_valid,
    input  logic        prt_ready,
    input  logic [5:0]  kbd_code,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    input  logic        ovr_clr,
    output logic        overrun
);
    // A zero duration still lasts one tick.
    localparam logic [15:0] ECHO_N = 16'(ECHO_MS < 1 ? 1 : ECHO_MS);
    localparam logic [15:0] KEY_N  = 16'(KEY_MS < 1 ? 1 : KEY_MS);
    localparam logic [15:0] GAP_N  = 16'(GAP_MS < 1 ? 1 : GAP_MS);

    typedef enum logic [2:0] {IDLE, PRINT_WAIT, ECHO, KEY, GAP} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        tp_q, ev, drop, done, pop, push, empty;
    logic [5:0]  head;

    assign ev   = TYPE_PULSE && !tp_q;
    assign drop = ev && (state != IDLE || !TYPE);
    assign done = tick_ms && cnt == 16'd1;
    assign pop  = state == IDLE && !(ev && TYPE) && !empty;
    assign push = kbd_valid && kbd_ready;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tp_q      <= 1'b0;
            prt_valid <= 1'b0;
            prt_data  <= '0;
            LEV_OUT   <= '0;
            KEY_LINES <= '0;
            overrun   <= 1'b0;
        end else begin
            tp_q    <= TYPE_PULSE;
            overrun <= drop || (overrun && !ovr_clr);
            if (tick_ms && cnt != '0) cnt <= cnt - 16'd1;
            case (state)
                IDLE:
                    if (ev && TYPE) begin
                        prt_data  <= OB;
                        prt_valid <= 1'b1;
                        state     <= PRINT_WAIT;
                    end else if (pop) begin
                        // Function indices 11..15 have no contact but still take key timing.
                        LEV_OUT   <= head[5] ? 5'd0 : head[4:0];
                        KEY_LINES <= (head[5] && head[3:0] < 4'd11) ? 11'd1 << head[3:0] : '0;
                        cnt       <= KEY_N;
                        state     <= KEY;
                    end
                PRINT_WAIT:
                    if (prt_ready) begin
                        prt_valid <= 1'b0;
                        LEV_OUT   <= prt_data;
                        cnt       <= ECHO_N;
                        state     <= ECHO;
                    end
                ECHO, KEY:
                    if (done) begin
                        LEV_OUT   <= '0;
                        KEY_LINES <= '0;
                        cnt       <= GAP_N;
                        state     <= GAP;
                    end
                GAP:
                    if (done) state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

`ifdef G15_COUPLER_KBD_FIFO_EN
    logic [5:0] mem [4];
    logic [1:0] wp, rp;
    logic [2:0] fill;

    assign empty     = fill == 3'd0;
    assign kbd_ready = !rst && fill != 3'd4;
    assign head      = mem[rp];

    always_ff @(posedge CLOCK)
        if (push) mem[wp] <= kbd_code;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            fill <= '0;
        end else begin
            if (push) wp <= wp + 2'd1;
            if (pop) rp <= rp + 2'd1;
            fill <= fill + {2'b0, push} - {2'b0, pop};
        end
    end
`else
    logic [5:0] hold;
    logic       full;

    assign empty     = !full;
    assign kbd_ready = !rst && !full;
    assign head      = hold;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            hold <= '0;
            full <= 1'b0;
        end else begin
            if (push) hold <= kbd_code;
            full <= push || (full && !pop);
        end
    end
`endif
endmodule

// File: tb/tb_typewriter_coupler.sv
// tb_typewriter_coupler: directed and randomized checks of typewriter_coupler against a run-level timing model.
module tb_typewriter_coupler;
    logic        CLOCK = 0, rst = 1, tick_ms = 0, TYPE = 0, TYPE_PULSE = 0;
    logic        prt_ready = 1, kbd_valid = 0, ovr_clr = 0;
    logic [4:0]  OB = '0;
    logic [5:0]  kbd_code = '0;
    logic [4:0]  LEV_OUT, prt_data;
    logic [10:0] KEY_LINES;
    logic        prt_valid, kbd_ready, overrun;

    localparam int ECHO = 40, KEY = 50, GAP = 10;
`ifdef G15_COUPLER_KBD_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {logic [4:0] lev; logic [10:0] lines; int ticks; int gap;} run_t;

    run_t        runs[$], exp_runs[$];
    logic [15:0] mon_cur = '0;
    int          mon_tk = 0, mon_gap = 0;
    int          passed = 0, total = 0, carry = 0, pv, k;
    bit          known = 0;
    logic [4:0]  ob, pd;
    logic [5:0]  keys[5] = '{6'b100011, 6'b001010, 6'b100001, 6'b101010, 6'b010101};
    logic [5:0]  rk[8];

    typewriter_coupler dut (
        .CLOCK(CLOCK), .rst(rst), .tick_ms(tick_ms), .TYPE(TYPE), .TYPE_PULSE(TYPE_PULSE),
        .OB(OB), .LEV_OUT(LEV_OUT), .KEY_LINES(KEY_LINES), .prt_data(prt_data),
        .prt_valid(prt_valid), .prt_ready(prt_ready), .kbd_code(kbd_code),
        .kbd_valid(kbd_valid), .kbd_ready(kbd_ready), .ovr_clr(ovr_clr), .overrun(overrun)
    );

    always #5 CLOCK = ~CLOCK;

    // Ticks are at least three idle cycles apart so the one-cycle IDLE hop never swallows one.
    initial forever begin
        repeat ($urandom_range(3, 6)) @(posedge CLOCK);
        #1 tick_ms = 1;
        @(posedge CLOCK);
        #1 tick_ms = 0;
    end

    // Splits the output into runs of constant non-zero value: ticks inside, and ticks in the zero run before.
    always @(negedge CLOCK) begin
        if (rst) begin
            mon_cur = '0;
            mon_tk  = 0;
        end else begin
            if ({LEV_OUT, KEY_LINES} != mon_cur) begin
                if (mon_cur != '0) runs.push_back('{mon_cur[15:11], mon_cur[10:0], mon_tk, mon_gap});
                else mon_gap = mon_tk;
                mon_cur = {LEV_OUT, KEY_LINES};
                mon_tk  = 0;
            end
            if (tick_ms) mon_tk++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic start_chain();
        known = 0;
        carry = 0;
    endtask

    task automatic add_print(input logic [4:0] c);
        exp_runs.push_back('{c, 11'd0, ECHO, known ? GAP + carry : -1});
        known = 1;
        carry = 0;
    endtask

    task automatic add_key(input logic [5:0] c);
        run_t e;
        e.lev   = c[5] ? 5'd0 : c[4:0];
        e.lines = '0;
        if (c[5] && c[3:0] < 4'd11) e.lines[c[3:0]] = 1'b1;
        e.ticks = KEY;
        e.gap   = known ? GAP + carry : -1;
        if (e.lev != '0 || e.lines != '0) begin
            exp_runs.push_back(e);
            known = 1;
            carry = 0;
        end else if (known) carry += KEY + GAP;
    endtask

    task automatic check_runs();
        run_t e, r;
        int n = 0;
        int budget = exp_runs.size() * 600 + 1000;
        while (runs.size() < exp_runs.size() && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        chk("run_count", runs.size(), exp_runs.size());
        while (exp_runs.size() > 0 && runs.size() > 0) begin
            e = exp_runs.pop_front();
            r = runs.pop_front();
            chk("run_lev", r.lev, e.lev);
            chk("run_lines", r.lines, e.lines);
            chk("run_ticks", r.ticks, e.ticks);
            if (e.gap >= 0) chk("run_gap", r.gap, e.gap);
        end
        exp_runs.delete();
        runs.delete();
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(negedge CLOCK);
            if (tick_ms) c++;
        end
    endtask

    task automatic wait_lev();
        int n = 0;
        while (LEV_OUT == '0 && n < 2000) begin
            @(negedge CLOCK);
            n++;
        end
        chk("lev_start", LEV_OUT != '0, 1);
    endtask

    task automatic pulse(input logic [4:0] c, input logic ty, input int len);
        @(negedge CLOCK);
        TYPE = ty;
        OB = c;
        TYPE_PULSE = 1;
        repeat (len) @(negedge CLOCK);
        TYPE_PULSE = 0;
    endtask

    task automatic push_key(input logic [5:0] c);
        int n = 0;
        @(negedge CLOCK);
        kbd_code = c;
        kbd_valid = 1;
        while (!kbd_ready && n < 5000) begin
            @(negedge CLOCK);
            n++;
        end
        chk("kbd_accept", kbd_ready, 1);
        @(negedge CLOCK);
        kbd_valid = 0;
    endtask

    initial begin
        repeat (3) @(negedge CLOCK);
        chk("rst_lev", LEV_OUT, 0);
        chk("rst_lines", KEY_LINES, 0);
        chk("rst_prt_valid", prt_valid, 0);
        chk("rst_prt_data", prt_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_kbd_ready", kbd_ready, 0);
        rst = 0;
        @(negedge CLOCK);
        chk("kbd_ready_idle", kbd_ready, 1);

        // Held strobe is one event; one-cycle prt_valid; exact echo length.
        start_chain();
        add_print(5'b10110);
        @(negedge CLOCK);
        TYPE = 1;
        OB = 5'b10110;
        TYPE_PULSE = 1;
        pv = 0;
        pd = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK);
            if (i == 2) TYPE_PULSE = 0;
            if (prt_valid) begin
                pv++;
                pd = prt_data;
            end
        end
        chk("prt_valid_cycles", pv, 1);
        chk("prt_data", pd, 5'b10110);
        check_runs();
        wait_ticks(12);

        // Host back-pressure holds the character.
        start_chain();
        add_print(5'b01011);
        prt_ready = 0;
        pulse(5'b01011, 1, 1);
        repeat (5) @(negedge CLOCK);
        chk("bp_valid_held", prt_valid, 1);
        chk("bp_data_held", prt_data, 5'b01011);
        chk("bp_no_echo", LEV_OUT, 0);
        prt_ready = 1;
        check_runs();
        wait_ticks(12);

        // Keys queued behind an echo emerge in order with gaps.
        start_chain();
        add_print(5'b00101);
        for (int i = 0; i < 5; i++) add_key(keys[i]);
        pulse(5'b00101, 1, 1);
        wait_lev();
        push_key(keys[0]);
        chk("kbd_ready_after_1", kbd_ready, DEPTH > 1);
        for (int i = 1; i < DEPTH; i++) push_key(keys[i]);
        chk("kbd_full", kbd_ready, 0);
        for (int i = DEPTH; i < 5; i++) push_key(keys[i]);
        check_runs();
        wait_ticks(12);

        // Print beats an eligible keystroke in the same cycle.
        start_chain();
        add_print(5'b11001);
        add_key(6'b100101);
        @(negedge CLOCK);
        kbd_code = 6'b100101;
        kbd_valid = 1;
        @(negedge CLOCK);
        kbd_valid = 0;
        TYPE = 1;
        OB = 5'b11001;
        TYPE_PULSE = 1;
        @(negedge CLOCK);
        TYPE_PULSE = 0;
        check_runs();
        wait_ticks(12);

        // Overrun during echo, clear, set-wins, TYPE=0 drop.
        start_chain();
        add_print(5'b00111);
        pulse(5'b00111, 1, 1);
        wait_lev();
        OB = 5'b11000;
        pulse(5'b11000, 1, 1);
        chk("ovr_set", overrun, 1);
        chk("ovr_prt_data_kept", prt_data, 5'b00111);
        check_runs();
        wait_ticks(12);
        @(negedge CLOCK);
        ovr_clr = 1;
        @(negedge CLOCK);
        ovr_clr = 0;
        chk("ovr_clear", overrun, 0);
        @(negedge CLOCK);
        TYPE = 0;
        TYPE_PULSE = 1;
        ovr_clr = 1;
        @(negedge CLOCK);
        TYPE_PULSE = 0;
        ovr_clr = 0;
        chk("ovr_set_wins", overrun, 1);
        chk("type0_no_valid", prt_valid, 0);
        wait_ticks(60);
        chk("type0_no_run", runs.size(), 0);
        @(negedge CLOCK);
        ovr_clr = 1;
        @(negedge CLOCK);
        ovr_clr = 0;
        chk("ovr_clear2", overrun, 0);

        // Reset mid-echo with a key waiting.
        pulse(5'b01101, 1, 1);
        wait_lev();
        push_key(6'b000111);
        k = 0;
        while (k < 20) begin
            @(negedge CLOCK);
            if (tick_ms) k++;
        end
        #2 rst = 1;
        #1;
        chk("rst_async_lev", LEV_OUT, 0);
        chk("rst_async_lines", KEY_LINES, 0);
        chk("rst_async_prt_data", prt_data, 0);
        chk("rst_async_prt_valid", prt_valid, 0);
        chk("rst_async_overrun", overrun, 0);
        chk("rst_async_kbd_ready", kbd_ready, 0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        rst = 0;
        runs.delete();
        exp_runs.delete();
        start_chain();
        add_print(5'b10011);
        pulse(5'b10011, 1, 1);
        check_runs();
        wait_ticks(80);
        chk("rst_key_lost", runs.size(), 0);

        // Random prints.
        for (int i = 0; i < 4; i++) begin
            ob = 5'($urandom_range(1, 31));
            start_chain();
            add_print(ob);
            pulse(ob, 1, $urandom_range(1, 4));
            check_runs();
            wait_ticks(12);
        end

        // Random key chain, including codes that drive nothing.
        start_chain();
        for (int i = 0; i < 8; i++) begin
            rk[i] = 6'($urandom_range(0, 63));
            add_key(rk[i]);
        end
        for (int i = 0; i < 8; i++) push_key(rk[i]);
        check_runs();
        wait_ticks(12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/typewriter_coupler.md
TYPEWRITER_COUPLER -- requirements
Module: typewriter_coupler

Interface
REQ-001 SHALL provide parameter ECHO_MS, default 40: print echo duration in tick_ms pulses.
REQ-002 SHALL provide parameter KEY_MS, default 50: key/data strobe duration in tick_ms pulses.
REQ-003 SHALL provide parameter GAP_MS, default 10: mandatory idle gap after every echo or key, in tick_ms pulses.
REQ-004 SHALL have port CLOCK  in  1  sole clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tick_ms  in  1  one-CLOCK pulse per millisecond.
REQ-007 SHALL have port TYPE  in  1  computer type mode (PL1-33).
REQ-008 SHALL have port TYPE_PULSE  in  1  character strobe from computer (PL1-29 EXC).
REQ-009 SHALL have port OB  in  5  character code OB5..OB1 (PL1-27,23,24,25,26).
REQ-010 SHALL have port LEV_OUT  out  5  echo/data levels LEV5..LEV1 (PL1-12,16,15,14,13).
REQ-011 SHALL have port KEY_LINES  out  11  bit0..10 = Ⓢ,A,B,C,I,M,P,Q,R,T,F-B key contacts.
REQ-012 SHALL have port prt_data  out  5  captured character to host.
REQ-013 SHALL have ports prt_valid out 1 / prt_ready in 1: print handshake.
REQ-014 SHALL have port kbd_code  in  6  bit5=1: function key, index in [3:0]; bit5=0: data code in [4:0].
REQ-015 SHALL have ports kbd_valid in 1 / kbd_ready out 1: keystroke handshake.
REQ-016 SHALL have ports ovr_clr in 1 / overrun out 1: sticky dropped-character flag and its clear.

Function
REQ-017 SHALL register TYPE_PULSE; event = current sample high & previous sample low.
REQ-018 SHALL use states IDLE, PRINT_WAIT, ECHO, KEY, GAP.
REQ-019 IDLE + event + TYPE=1: capture OB into prt_data, assert prt_valid on the same edge, go to PRINT_WAIT.
REQ-020 PRINT_WAIT: hold prt_data/prt_valid stable; on prt_valid & prt_ready, deassert prt_valid, load counter ECHO_MS, drive LEV_OUT=prt_data, go to ECHO.
REQ-021 IDLE, no print event, keystroke pending: pop; function key asserts KEY_LINES[index]; data asserts LEV_OUT=code; load counter KEY_MS; go to KEY.
REQ-022 Function index 11..15 SHALL be consumed with no line asserted and still run KEY and GAP timing.
REQ-023 Print event SHALL win over a pending keystroke in the same cycle; the keystroke remains queued.
REQ-024 Counter SHALL decrement only on tick_ms; a phase ends on the edge where the Nth tick_ms is counted; N=0 is treated as 1.
REQ-025 End of ECHO or KEY: LEV_OUT and KEY_LINES go to 0, load GAP_MS, go to GAP; end of GAP go to IDLE.
REQ-026 Event in any state but IDLE, or event with TYPE=0, SHALL drop the character and set overrun.
REQ-027 overrun SHALL clear on ovr_clr unless a new drop occurs the same cycle (set wins).
REQ-028 At most one KEY_LINES bit SHALL be high, and never concurrently with a non-zero LEV_OUT.

Reset
REQ-029 rst SHALL force IDLE, counter 0, TYPE_PULSE history 0, prt_valid 0, prt_data 0, LEV_OUT 0, KEY_LINES 0, overrun 0, keystroke storage empty, kbd_ready 0 while rst high.
REQ-030 rst mid-ECHO or mid-KEY SHALL drop levels immediately; the in-flight character/key is lost.

Configuration
REQ-031 Macro G15_COUPLER_KBD_FIFO_EN defined: keystroke storage SHALL be a 4-entry FIFO; kbd_ready = not full; push order = pop order.
REQ-032 Macro absent: storage SHALL be one holding register; kbd_ready = register empty.
REQ-033 Either build: push on kbd_valid & kbd_ready; a keystroke pushed is eligible for pop no earlier than the next cycle.

Verification
REQ-034 TYPE=1, OB=5'b10110, TYPE_PULSE 3 cycles, prt_ready=1 -> prt_data=10110 one pulse, LEV_OUT=10110 for exactly 40 tick_ms, 0 for 10 more, then IDLE.
REQ-035 kbd_code=6'b100011 (key C) -> KEY_LINES=11'b00000001000 for 50 tick_ms, kbd_ready behaviour per build, next key not started before 10-tick gap.
REQ-036 Second TYPE_PULSE during ECHO -> overrun=1, echo unaffected; ovr_clr -> overrun=0.
REQ-037 With FIFO: push 5 keys back-to-back -> kbd_ready low after 4th; keys emerge in order. Without: kbd_ready low after 1st.
REQ-038 Keystroke pending and print event same cycle -> print served first, key follows after gap.
REQ-039 rst asserted at tick 20 of ECHO -> LEV_OUT=0 asynchronously, all outputs at reset values, normal print after release.
